// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the 65C02 memory bus controller:
//   - state_t      : controller state encoding (RUN / WAIT / ACK / DONE)
//   - TMR_W        : width of the shared wait/timeout counter
//   - BUS_ERR_FILL : read data returned to the core when a slow access times out
// -----------------------------------------------------------------------------
package mem_if_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int          TMR_W        = 8;
   localparam logic [7:0]  BUS_ERR_FILL = 8'hFF;

endpackage

// File: rtl/mem_if_timer.sv
// -----------------------------------------------------------------------------
// mem_if_timer
// Loadable 8-bit up/down counter with a terminal flag. One instance serves both
// the wait-state countdown and the handshake timeout count-up, since those two
// phases never overlap.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val this cycle (wins over en)
//   load_val in   value to load
//   en       in   count this cycle
//   up       in   1 = increment, 0 = decrement
//   term_val in   value at which term is flagged
//   term     out  count == term_val (combinational from the register)
// -----------------------------------------------------------------------------
module mem_if_timer
   import mem_if_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic [TMR_W-1:0] term_val,
   output logic             term
);

   logic [TMR_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         if (up) count <= count + 1'b1;
         else    count <= count - 1'b1;
      end
   end

   assign term = (count == term_val);

endmodule

// File: rtl/mem_if.sv
// -----------------------------------------------------------------------------
// mem_if
// Bus controller between the 65C02 core pins and two targets: zero-wait
// on-chip RAM (fast region) and a req/ack slow region with programmable wait
// states and a timeout. Generates the core's RDY and multiplexes its DI.
// Ports:
//   clk, RST_n          clock (rising edge) / async active-low reset
//   AD, DO, WE          core address, write data, write enable
//   rdy_in              external stall request, 1 = run
//   RDY, DI             ready and read data to the core
//   fast_we, fast_rdata on-chip RAM write strobe / registered read data
//   ext_req, ext_we     slow-region request (held until ack/timeout), write flag
//   ext_addr, ext_wdata latched slow address / write data
//   ext_ack, ext_rdata  slow completion pulse / read data valid with ack
//   bus_err             one-cycle pulse when a slow access times out
// -----------------------------------------------------------------------------
module mem_if
   import mem_if_pkg::*;
#(
   parameter logic [15:0] SLOW_BASE   = 16'hC000,
   parameter logic [15:0] SLOW_MASK   = 16'hF000,
   parameter int          WAIT_CYCLES = 2,
   parameter int          TIMEOUT     = 64
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic [15:0] AD,
   input  logic [7:0]  DO,
   input  logic        WE,
   input  logic        rdy_in,
   output logic        RDY,
   output logic [7:0]  DI,
   output logic        fast_we,
   input  logic [7:0]  fast_rdata,
   output logic        ext_req,
   output logic        ext_we,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   input  logic        ext_ack,
   input  logic [7:0]  ext_rdata,
   output logic        bus_err
);

   localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(WAIT_CYCLES);
   localparam logic [TMR_W-1:0] TO_TERM   = TMR_W'(TIMEOUT - 1);

   state_t           state, next_state;
   logic             slow;
   logic             rdy_c, fwe_c;
   logic             latch_en, cap_en;
   logic [7:0]       cap_val, cap_data;
   logic             tmr_load, tmr_en, tmr_up, tmr_term;
   logic [TMR_W-1:0] tmr_load_val, tmr_term_val;

   assign slow = ((AD & SLOW_MASK) == SLOW_BASE);

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) state <= ST_RUN;
      else        state <= next_state;
   end

   always_comb begin
      next_state   = state;
      rdy_c        = 1'b0;
      fwe_c        = 1'b0;
      DI           = fast_rdata;
      ext_req      = 1'b0;
      bus_err      = 1'b0;
      latch_en     = 1'b0;
      cap_en       = 1'b0;
      cap_val      = ext_rdata;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_en       = 1'b0;
      tmr_up       = 1'b0;
      tmr_term_val = TMR_W'(1);

      case (state)
         ST_RUN: begin
            // Slow decode stalls the core combinationally in the same cycle.
            rdy_c = rdy_in & ~slow;
            fwe_c = WE & rdy_c;
            if (slow && rdy_in) begin
               latch_en     = 1'b1;
               tmr_load     = 1'b1;
               tmr_load_val = WAIT_LOAD;
               next_state   = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
            end
         end

         ST_WAIT: begin
            // Leave when the countdown reads 1, so exactly WAIT_CYCLES cycles
            // are spent here; reload 0 for the timeout count-up.
            tmr_en = 1'b1;
            if (tmr_term) begin
               tmr_load     = 1'b1;
               tmr_load_val = '0;
               next_state   = ST_ACK;
            end
         end

         ST_ACK: begin
            ext_req      = 1'b1;
            tmr_en       = 1'b1;
            tmr_up       = 1'b1;
            tmr_term_val = TO_TERM;
            // A late ack coinciding with the timeout still counts as success.
            if (ext_ack) begin
               cap_en     = 1'b1;
               cap_val    = ext_rdata;
               next_state = ST_DONE;
            end else if (tmr_term) begin
               cap_en     = 1'b1;
               cap_val    = BUS_ERR_FILL;
               bus_err    = 1'b1;
               next_state = ST_DONE;
            end
         end

         ST_DONE: begin
            DI    = cap_data;
            rdy_c = rdy_in;
            if (rdy_in) next_state = ST_RUN;
         end

         default: next_state = ST_RUN;
      endcase

      // State is held in RUN during reset, so only the core-facing strobes
      // need explicit gating.
      RDY     = rdy_c & RST_n;
      fast_we = fwe_c & RST_n;
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         ext_addr  <= '0;
         ext_we    <= 1'b0;
         ext_wdata <= '0;
      end else if (latch_en) begin
         ext_addr  <= AD;
         ext_we    <= WE;
         ext_wdata <= DO;
      end
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n)      cap_data <= 8'h00;
      else if (cap_en) cap_data <= cap_val;
   end

   mem_if_timer u_timer (
      .clk      (clk),
      .rst_n    (RST_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .en       (tmr_en),
      .up       (tmr_up),
      .term_val (tmr_term_val),
      .term     (tmr_term)
   );

endmodule

// File: tb/tb_mem_if.sv
module tb_mem_if;

   logic        clk = 1'b0;
   logic        RST_n;
   logic [15:0] AD;
   logic [7:0]  DO;
   logic        WE;
   logic        rdy_in;
   logic        RDY;
   logic [7:0]  DI;
   logic        fast_we;
   logic [7:0]  fast_rdata;
   logic        ext_req;
   logic        ext_we;
   logic [15:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic        ext_ack;
   logic [7:0]  ext_rdata;
   logic        bus_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   mem_if #(
      .SLOW_BASE   (16'hC000),
      .SLOW_MASK   (16'hF000),
      .WAIT_CYCLES (2),
      .TIMEOUT     (64)
   ) dut (
      .clk        (clk),
      .RST_n      (RST_n),
      .AD         (AD),
      .DO         (DO),
      .WE         (WE),
      .rdy_in     (rdy_in),
      .RDY        (RDY),
      .DI         (DI),
      .fast_we    (fast_we),
      .fast_rdata (fast_rdata),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_ack    (ext_ack),
      .ext_rdata  (ext_rdata),
      .bus_err    (bus_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] ad;
      logic        we;
      logic        rdy;
      logic [7:0]  frd;
      logic        e_rdy;
      logic        e_fwe;
      logic [7:0]  e_di;
   } vec_t;

   vec_t vecs[9];

   // One slow access from RUN back to RDY=1 in DONE. ack_delay = ACK cycle on
   // which ext_ack is pulsed (0 = never). stall = DONE cycles with rdy_in=0.
   task automatic slow_access(input string tag, input logic [15:0] addr, input logic we,
                              input logic [7:0] wdata, input int ack_delay,
                              input logic [7:0] rdata, input int stall,
                              input int exp_low, input int exp_req, input int exp_err,
                              input logic [7:0] exp_di);
      int   low = 0, req = 0, errs = 0, stalled = 0;
      bit   finished = 0, rdy_bad = 0, hold_bad = 0, fwe_seen = 0, stall_bad = 0;
      logic [7:0] got;
      exp_q.push_back(exp_di);
      @(negedge clk);
      AD = addr; WE = we; DO = wdata; rdy_in = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         #1;
         if (!ext_req && req > 0) begin
            if (stalled == stall) begin
               rdy_in = 1'b1;
               #1;
               finished = 1;
               break;
            end
            stalled++;
            if (RDY !== 1'b0 || DI !== exp_di) stall_bad = 1;
         end else begin
            low++;
            if (RDY !== 1'b0) rdy_bad = 1;
            if (fast_we !== 1'b0) fwe_seen = 1;
            if (ext_req) begin
               req++;
               if (ext_addr !== addr || ext_we !== we || ext_wdata !== wdata) hold_bad = 1;
               if (req == ack_delay) begin
                  ext_ack = 1'b1;
                  ext_rdata = rdata;
                  if (stall > 0) rdy_in = 1'b0;
               end
               #1;
               if (bus_err) errs++;
            end
         end
         @(negedge clk);
         ext_ack = 1'b0;
         ext_rdata = 8'hEE;
      end
      check({tag, "_finished"}, finished, 1);
      check({tag, "_rdy_done"}, RDY, 1);
      check({tag, "_req_done"}, ext_req, 0);
      got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check({tag, "_di"}, DI, got);
      check({tag, "_rdy_low_cycles"}, low, exp_low);
      check({tag, "_req_cycles"}, req, exp_req);
      check({tag, "_bus_err_pulses"}, errs, exp_err);
      check({tag, "_rdy_low_bad"}, rdy_bad, 0);
      check({tag, "_hold_bad"}, hold_bad, 0);
      check({tag, "_fast_we_seen"}, fwe_seen, 0);
      if (stall > 0) check({tag, "_stall_bad"}, stall_bad, 0);
      // Core moves to a fast address after consuming DI; DONE -> RUN.
      @(negedge clk);
      AD = 16'h0000; WE = 1'b0;
      #1;
      check({tag, "_back_run"}, RDY, 1);
      check({tag, "_addr_kept"}, ext_addr, addr);
   endtask

   initial begin
      int cnt;
      vecs[0] = '{16'h0200, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C};
      vecs[1] = '{16'h0200, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'hA1};
      vecs[2] = '{16'h0200, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h11};
      vecs[3] = '{16'hBFFF, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22};
      vecs[4] = '{16'hD000, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 8'h33};
      vecs[5] = '{16'hC000, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 8'h44};
      vecs[6] = '{16'hCFFF, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55};
      vecs[7] = '{16'hFFFF, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 8'h66};
      vecs[8] = '{16'h0000, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h77};

      RST_n = 1'b0; AD = 16'h0200; DO = 8'h5A; WE = 1'b1; rdy_in = 1'b1;
      fast_rdata = 8'h00; ext_ack = 1'b0; ext_rdata = 8'hEE;
      repeat (3) @(negedge clk);
      #1;
      check("rst_rdy", RDY, 0);
      check("rst_fast_we", fast_we, 0);
      check("rst_ext_req", ext_req, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_ext_we", ext_we, 0);
      check("rst_ext_addr", ext_addr, 16'h0000);
      check("rst_ext_wdata", ext_wdata, 8'h00);
      @(negedge clk);
      RST_n = 1'b1;

      // Fast path and decode boundaries, all in RUN.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         AD = vecs[i].ad; WE = vecs[i].we; rdy_in = vecs[i].rdy;
         fast_rdata = vecs[i].frd; DO = 8'h5A;
         #1;
         check($sformatf("vec%0d_rdy", i), RDY, vecs[i].e_rdy);
         check($sformatf("vec%0d_fast_we", i), fast_we, vecs[i].e_fwe);
         check($sformatf("vec%0d_di", i), DI, vecs[i].e_di);
         check($sformatf("vec%0d_ext_req", i), ext_req, 0);
      end

      // W=2 wait cycles throughout: RDY low = 1 + 2 + ack cycles.
      slow_access("rd",      16'hC010, 1'b0, 8'h00, 1,  8'h3C, 0, 4,  1,  0, 8'h3C);
      slow_access("wr",      16'hC001, 1'b1, 8'hA5, 5,  8'h77, 0, 8,  5,  0, 8'h77);
      slow_access("timeout", 16'hC100, 1'b0, 8'h12, 0,  8'h00, 0, 67, 64, 1, 8'hFF);
      slow_access("ack_race",16'hC200, 1'b0, 8'h34, 64, 8'h9D, 0, 67, 64, 0, 8'h9D);
      slow_access("stall",   16'hC300, 1'b0, 8'h56, 1,  8'hC7, 3, 4,  1,  0, 8'hC7);

      // Reset in the middle of a handshake.
      @(negedge clk);
      AD = 16'hC020; WE = 1'b0; DO = 8'h00; rdy_in = 1'b1;
      cnt = 0;
      #1;
      while (!ext_req && cnt < 20) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      check("rst_mid_reach_ack", ext_req, 1);
      @(negedge clk);
      AD = 16'h0200; WE = 1'b1; DO = 8'h5A;
      #2;
      RST_n = 1'b0;
      #1;
      check("rst_mid_req_async", ext_req, 0);
      check("rst_mid_rdy", RDY, 0);
      check("rst_mid_fast_we", fast_we, 0);
      check("rst_mid_ext_addr", ext_addr, 16'h0000);
      repeat (2) @(negedge clk);
      RST_n = 1'b1;
      #1;
      check("post_rst_rdy", RDY, 1);
      check("post_rst_fast_we", fast_we, 1);
      check("post_rst_ext_req", ext_req, 0);
      @(negedge clk);
      #1;
      check("post_rst_rdy2", RDY, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_if.md
Name: mem_if

Overview:
- Memory bus controller between the 65C02 core's bus pins (AD, DO, WE, DI, RDY) and two memory targets.
- On-chip RAM is the fast region: zero wait states.
- A slow external/IO region is reached over a req/ack handshake, with programmable wait states and a timeout.
- The block generates the core's RDY and multiplexes its DI.

Parameters:
- SLOW_BASE, 16'hC000, base address of the slow region.
- SLOW_MASK, 16'hF000, a CPU address is slow when (AD & SLOW_MASK) == SLOW_BASE.
- WAIT_CYCLES, 2, idle cycles inserted before ext_req rises (0..15).
- TIMEOUT, 64, maximum cycles ext_req stays high without ext_ack (2..255).

Ports:
- clk  input  1  CPU clock; all state changes on the rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- AD  input  16  CPU address (combinational from the core).
- DO  input  8  CPU write data.
- WE  input  1  CPU write enable.
- rdy_in  input  1  external stall request (single-step/DMA); 1 = run.
- RDY  output  1  ready to the core.
- DI  output  8  read data to the core.
- fast_we  output  1  write strobe to on-chip RAM.
- fast_rdata  input  8  registered on-chip RAM read data.
- ext_req  output  1  slow-region request, held until ack or timeout.
- ext_we  output  1  slow access is a write.
- ext_addr  output  16  latched slow address.
- ext_wdata  output  8  latched slow write data.
- ext_ack  input  1  slow target completion, single-cycle pulse.
- ext_rdata  input  8  slow read data, valid with ext_ack.
- bus_err  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state RUN; ext_req=0, bus_err=0, ext_we=0;
  - ext_addr=0, ext_wdata=0, captured data=8'h00, counters=0.
  - ext_req drops immediately, even mid-handshake.
- Outputs while RST_n=0: RDY=0, fast_we=0.
- slow = ((AD & SLOW_MASK) == SLOW_BASE), combinational.
- States: RUN, WAIT, ACK, DONE. Encoding 2 bits.
- RUN:
  - RDY = rdy_in & ~slow, combinational path AD→RDY.
  - DI = fast_rdata; fast_we = WE & RDY.
  - If slow & rdy_in: latch AD→ext_addr, WE→ext_we, DO→ext_wdata. Load wait counter with WAIT_CYCLES. Go to WAIT, or straight to ACK when WAIT_CYCLES=0.
  - If slow & ~rdy_in: stay in RUN; no access starts.
- WAIT:
  - RDY=0. Decrement the counter each cycle.
  - When it reads 1, go to ACK.
  - Net effect: WAIT_CYCLES cycles spent in WAIT.
- ACK:
  - ext_req=1, RDY=0. Timeout counter increments from 0.
  - ext_ack=1: capture ext_rdata, go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1: capture 8'hFF, pulse bus_err for that cycle, go to DONE, drop ext_req.
  - ext_ack arriving in the same cycle as the timeout wins: no bus_err.
- DONE:
  - ext_req=0. DI = captured data. RDY = rdy_in. fast_we=0.
  - rdy_in=1: the core consumes DI/completes the write at this edge; go to RUN.
  - rdy_in=0: remain in DONE with data held; no new ext_req.
- Latency, slow access: RDY low for 1 + WAIT_CYCLES + (ack delay) cycles. A minimal read with WAIT_CYCLES=0 and ext_ack in the first ACK cycle gives RDY=0 for 2 cycles (RUN detect, ACK), then RDY=1 in DONE.
- rdy_in=0 while in WAIT or ACK does not pause the slow access. It only delays the exit from DONE.
- ext_ack outside ACK is ignored.
- Back-to-back slow accesses: from DONE back to RUN, the next slow AD restarts the sequence. There is no pipelining.
- ext_addr, ext_we and ext_wdata are stable from the latch until the next slow access starts.

Decomposition:
- Shared package (mem_if_pkg): state encoding constants (RUN/WAIT/ACK/DONE) and the bus-error fill value 8'hFF. Region parameters stay module parameters.
- One natural sub-module, mem_if_timer: loadable 8-bit down/up counter with terminal flag. It is used for both the wait and timeout counts.

Test Plan:
- Fast path: RST_n=0 for 3 clocks, release, AD=16'h0200, WE=1, DO=8'h5A, rdy_in=1 → RDY=1, fast_we=1, ext_req never rises.
- Slow read, WAIT_CYCLES=2: AD=16'hC010, WE=0; ack on the first ACK cycle with ext_rdata=8'h3C → RDY=0 for exactly 4 cycles, ext_addr=16'hC010, then DI=8'h3C with RDY=1 for one cycle, back to RUN.
- Slow write: AD=16'hC001, WE=1, DO=8'hA5; ack after 5 ACK cycles → ext_we=1, ext_wdata=8'hA5 held for all 5 cycles; fast_we stays 0.
- Timeout, TIMEOUT=64: no ack → ext_req high exactly 64 cycles, bus_err single pulse, DI=8'hFF in DONE.
- Stall: rdy_in=0 on entry to DONE for 3 cycles → RDY=0, DI held at captured value, ext_req=0; RDY=1 on the cycle rdy_in returns.
- Reset mid-op: assert RST_n=0 during ACK → ext_req falls without waiting for clk; after release, state is RUN and the next fast access completes with RDY=1.
